blob_corner_tracker: RTL

BLOB_CORNER_TRACKER -- requirements
Module: blob_corner_tracker

---
 rtl/blob_corner_tracker_pkg.sv | 16 +
 rtl/blob_channel.sv | 134 +++++++++++++
 rtl/blob_corner_tracker.sv | 112 +++++++++++
 3 files changed

// File: rtl/blob_corner_tracker_pkg.sv
// Shared constants for the blob corner tracker: corner codes and default raster size.
package blob_corner_tracker_pkg;

  typedef enum logic [2:0] {
    CORNER_NONE  = 3'd0,
    CORNER_TL    = 3'd1,
    CORNER_TR    = 3'd2,
    CORNER_BL    = 3'd3,
    CORNER_BR    = 3'd4,
    CORNER_MATCH = 3'd5
  } corner_e;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/blob_channel.sv
// One colour channel: chroma window match, history gate, running extremes/count,
// per-frame latch of corners and count, and the per-pixel corner code.
module blob_channel
  import blob_corner_tracker_pkg::*;
#(
  parameter int HIST_W   = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int CNT_W    = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  input  logic                         frame_edge,
  input  logic [7:0]                   cb,
  input  logic [7:0]                   cr,
  input  logic [7:0]                   cb_lo,
  input  logic [7:0]                   cb_hi,
  input  logic [7:0]                   cr_lo,
  input  logic [7:0]                   cr_hi,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [HIST_W-1:0]            history,
  input  logic [$clog2(HIST_W+1)-1:0]  threshold_history,
  input  logic [CNT_W-1:0]             min_pixels,
  output logic                         match,
  output logic [2:0]                   code,
  output logic [9:0]                   tl_x,
  output logic [9:0]                   tl_y,
  output logic [9:0]                   tr_x,
  output logic [9:0]                   tr_y,
  output logic [9:0]                   bl_x,
  output logic [9:0]                   bl_y,
  output logic [9:0]                   br_x,
  output logic [9:0]                   br_y,
  output logic [CNT_W-1:0]             count,
  output logic                         blob_valid
);

  localparam int PC_W = $clog2(HIST_W + 1);
  localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
  localparam logic [9:0] X_START = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_START = 10'(V_ACTIVE - 1);

  logic [PC_W-1:0]  ones;
  logic             qual;
  corner_e          code_next;
  corner_e          code_reg;

  logic [9:0]       x_max_reg, x_min_reg, y_max_reg, y_min_reg;
  logic [9:0]       tl_x_reg, tl_y_reg, tr_x_reg, tr_y_reg;
  logic [9:0]       bl_x_reg, bl_y_reg, br_x_reg, br_y_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign match = (cb >= cb_lo) && (cb <= cb_hi) && (cr >= cr_lo) && (cr <= cr_hi);

  always_comb begin
    ones = '0;
    for (int i = 0; i < HIST_W; i++) ones = ones + PC_W'(history[i]);
  end

  // A pixel arriving on the frame edge belongs to neither frame and is dropped.
  assign qual = pix_valid && !frame_edge && match && (ones > threshold_history) &&
                (x < H_LIM) && (y < V_LIM);

  always_comb begin
    code_next = CORNER_NONE;
    if (qual) begin
      if (x == tl_x && y == tl_y)      code_next = CORNER_TL;
      else if (x == tr_x && y == tr_y) code_next = CORNER_TR;
      else if (x == bl_x && y == bl_y) code_next = CORNER_BL;
      else if (x == br_x && y == br_y) code_next = CORNER_BR;
      else                             code_next = CORNER_MATCH;
    end
  end

  assign code = code_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg   <= CORNER_NONE;
      x_max_reg  <= '0;
      x_min_reg  <= X_START;
      y_max_reg  <= '0;
      y_min_reg  <= Y_START;
      tl_x_reg   <= '0; tl_y_reg <= '0;
      tr_x_reg   <= '0; tr_y_reg <= '0;
      bl_x_reg   <= '0; bl_y_reg <= '0;
      br_x_reg   <= '0; br_y_reg <= '0;
      cnt_reg    <= '0;
      tl_x <= '0; tl_y <= '0; tr_x <= '0; tr_y <= '0;
      bl_x <= '0; bl_y <= '0; br_x <= '0; br_y <= '0;
      count      <= '0;
      blob_valid <= 1'b0;
    end else if (frame_edge) begin
      code_reg   <= CORNER_NONE;
      tl_x <= tl_x_reg; tl_y <= tl_y_reg;
      tr_x <= tr_x_reg; tr_y <= tr_y_reg;
      bl_x <= bl_x_reg; bl_y <= bl_y_reg;
      br_x <= br_x_reg; br_y <= br_y_reg;
      count      <= cnt_reg;
      blob_valid <= (cnt_reg >= min_pixels);
      x_max_reg  <= '0;
      x_min_reg  <= X_START;
      y_max_reg  <= '0;
      y_min_reg  <= Y_START;
      tl_x_reg   <= '0; tl_y_reg <= '0;
      tr_x_reg   <= '0; tr_y_reg <= '0;
      bl_x_reg   <= '0; bl_y_reg <= '0;
      br_x_reg   <= '0; br_y_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      code_reg <= code_next;
      if (qual) begin
        // Non-strict compares so that on ties the later pixel takes the corner.
        if (x >= x_max_reg) begin
          x_max_reg <= x; br_x_reg <= x; br_y_reg <= y;
        end
        if (x <= x_min_reg) begin
          x_min_reg <= x; tl_x_reg <= x; tl_y_reg <= y;
        end
        if (y >= y_max_reg) begin
          y_max_reg <= y; bl_x_reg <= x; bl_y_reg <= y;
        end
        if (y <= y_min_reg) begin
          y_min_reg <= y; tr_x_reg <= x; tr_y_reg <= y;
        end
        if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/blob_corner_tracker.sv
// Multi-channel blob corner tracker: VS edge detect, history write-back and
// frame_done at the top, per-channel tracking in blob_channel instances.
module blob_corner_tracker
  import blob_corner_tracker_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int HIST_W   = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int CNT_W    = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         VGA_VS,
  input  logic                         pix_valid,
  input  logic [7:0]                   Cb,
  input  logic [7:0]                   Cr,
  input  logic [9:0]                   read_x,
  input  logic [9:0]                   read_y,
  input  logic [18:0]                  read_addr,
  input  logic [NUM_CH*HIST_W-1:0]     color_history,
  input  logic [NUM_CH*8-1:0]          thr_cb_lo,
  input  logic [NUM_CH*8-1:0]          thr_cb_hi,
  input  logic [NUM_CH*8-1:0]          thr_cr_lo,
  input  logic [NUM_CH*8-1:0]          thr_cr_hi,
  input  logic [$clog2(HIST_W+1)-1:0]  threshold_history,
  input  logic [CNT_W-1:0]             min_pixels,
  output logic                         we,
  output logic [18:0]                  write_addr,
  output logic [NUM_CH*HIST_W-1:0]     updated_color_history,
  output logic [NUM_CH*3-1:0]          corner_detected,
  output logic [NUM_CH*10-1:0]         tl_x,
  output logic [NUM_CH*10-1:0]         tl_y,
  output logic [NUM_CH*10-1:0]         tr_x,
  output logic [NUM_CH*10-1:0]         tr_y,
  output logic [NUM_CH*10-1:0]         bl_x,
  output logic [NUM_CH*10-1:0]         bl_y,
  output logic [NUM_CH*10-1:0]         br_x,
  output logic [NUM_CH*10-1:0]         br_y,
  output logic [NUM_CH*CNT_W-1:0]      pixel_count,
  output logic [NUM_CH-1:0]            blob_valid,
  output logic                         frame_done
);

  logic                      vs_reg;
  logic                      frame_edge;
  logic [NUM_CH-1:0]         match;
  logic [NUM_CH*HIST_W-1:0]  history_next;

  assign frame_edge = vs_reg && !VGA_VS;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign history_next[gi*HIST_W +: HIST_W] =
        {color_history[gi*HIST_W +: HIST_W-1], match[gi]};

      blob_channel #(
        .HIST_W  (HIST_W),
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .CNT_W   (CNT_W)
      ) u_channel (
        .clk              (clk),
        .rst              (reset),
        .pix_valid        (pix_valid),
        .frame_edge       (frame_edge),
        .cb               (Cb),
        .cr               (Cr),
        .cb_lo            (thr_cb_lo[gi*8 +: 8]),
        .cb_hi            (thr_cb_hi[gi*8 +: 8]),
        .cr_lo            (thr_cr_lo[gi*8 +: 8]),
        .cr_hi            (thr_cr_hi[gi*8 +: 8]),
        .x                (read_x),
        .y                (read_y),
        .history          (color_history[gi*HIST_W +: HIST_W]),
        .threshold_history(threshold_history),
        .min_pixels       (min_pixels),
        .match            (match[gi]),
        .code             (corner_detected[gi*3 +: 3]),
        .tl_x             (tl_x[gi*10 +: 10]),
        .tl_y             (tl_y[gi*10 +: 10]),
        .tr_x             (tr_x[gi*10 +: 10]),
        .tr_y             (tr_y[gi*10 +: 10]),
        .bl_x             (bl_x[gi*10 +: 10]),
        .bl_y             (bl_y[gi*10 +: 10]),
        .br_x             (br_x[gi*10 +: 10]),
        .br_y             (br_y[gi*10 +: 10]),
        .count            (pixel_count[gi*CNT_W +: CNT_W]),
        .blob_valid       (blob_valid[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_reg                <= 1'b0;
      we                    <= 1'b0;
      write_addr            <= '0;
      updated_color_history <= '0;
      frame_done            <= 1'b0;
    end else begin
      vs_reg     <= VGA_VS;
      we         <= pix_valid && !frame_edge;
      frame_done <= frame_edge;
      if (pix_valid && !frame_edge) begin
        write_addr            <= read_addr;
        updated_color_history <= history_next;
      end
    end
  end

endmodule
